// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared fetch-side definitions: default address width, instruction length
// constants and the next-PC source encoding used by pc_unit.
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int DEFAULT_XLEN = 32;

   // Byte lengths of compressed and full-width instructions.
   localparam int ILEN_16 = 2;
   localparam int ILEN_32 = 4;

   typedef enum logic [2:0] {
      NPC_REDIRECT,
      NPC_HOLD,
      NPC_RAS,
      NPC_JUMP,
      NPC_SEQ
   } npc_src_e;

endpackage : riscv_pkg

// File: rtl/return_address_stack.sv
// ----------------------------------------------------------------------------
// return_address_stack
// Circular return-address stack. A push when full overwrites the oldest entry
// and the count saturates at RAS_DEPTH.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer and count only)
//   push        write push_data above the current top
//   pop         discard the top entry (ignored when empty)
//   replace     overwrite the top entry with push_data, count unchanged
//   push_data   link address to store
//   top         current top entry (meaningful only when count != 0)
//   count       number of valid entries, 0..RAS_DEPTH
// At most one of push/pop/replace is expected per cycle; push has priority.
// ----------------------------------------------------------------------------
module return_address_stack
   import riscv_pkg::*;
#(
   parameter int XLEN      = DEFAULT_XLEN,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         replace,
   input  logic [XLEN-1:0]              push_data,
   output logic [XLEN-1:0]              top,
   output logic [$clog2(RAS_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  entries_q [RAS_DEPTH];
   logic [XLEN-1:0]  entries_d [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;   // next free slot; top is wr_ptr_q-1
   logic [CNT_W-1:0] count_q,  count_d;
   logic [PTR_W-1:0] top_idx;

   // Power-of-two depth lets the pointer wrap naturally.
   assign top_idx = wr_ptr_q - PTR_W'(1);
   assign top     = entries_q[top_idx];
   assign count   = count_q;

   // NOTE: every variable gets its default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (push) begin
         entries_d[wr_ptr_q] = push_data;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(RAS_DEPTH)) begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (replace) begin
         entries_d[top_idx] = push_data;
      end else if (pop && (count_q != '0)) begin
         wr_ptr_d = wr_ptr_q - PTR_W'(1);
         count_d  = count_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the entry storage is deliberately left out of reset; count guards
   // every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule : return_address_stack

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
// Fetch program counter. Selects the next fetch address from an execute
// redirect, stall, predecoded return/jump hints or the sequential step, and
// maintains a return-address stack for call/return prediction.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            hold pc and RAS
//   redirect_valid   execute redirect, overrides stall
//   redirect_target  redirect address
//   jump_valid       instruction at pc is a direct jump to jump_target
//   jump_target      direct jump target
//   is_call          instruction at pc is a call (push link)
//   is_ret           instruction at pc is a return (pop)
//   is_compressed    instruction at pc is 16-bit (ignored when C_EXT = 0)
//   pc               registered fetch address
//   misalign         registered pc has bit 1 set while C_EXT = 0
//   ras_count        valid RAS entries
// ----------------------------------------------------------------------------
module pc_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN         = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4,
   parameter bit              C_EXT        = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_target,
   input  logic                         jump_valid,
   input  logic [XLEN-1:0]              jump_target,
   input  logic                         is_call,
   input  logic                         is_ret,
   input  logic                         is_compressed,
   output logic [XLEN-1:0]              pc,
   output logic                         misalign,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] ilen, link, target, ras_top;
   logic            ras_update, ras_push, ras_pop, ras_replace, ras_nonempty;
   npc_src_e        npc_src;

   assign ilen         = (C_EXT && is_compressed) ? XLEN'(ILEN_16) : XLEN'(ILEN_32);
   assign link         = pc_q + ilen;
   assign ras_nonempty = (ras_count != '0);

   // Redirects and stalls freeze the stack. A call+ret pair on an empty
   // stack has nothing to replace, so it becomes a plain push.
   assign ras_update  = !stall && !redirect_valid;
   assign ras_push    = ras_update && is_call && (!is_ret || !ras_nonempty);
   assign ras_replace = ras_update && is_call && is_ret && ras_nonempty;
   assign ras_pop     = ras_update && is_ret && !is_call;

   always_comb begin
      npc_src = NPC_SEQ;
      if (redirect_valid)              npc_src = NPC_REDIRECT;
      else if (stall)                  npc_src = NPC_HOLD;
      else if (is_ret && ras_nonempty) npc_src = NPC_RAS;
      else if (jump_valid)             npc_src = NPC_JUMP;
   end

   always_comb begin
      case (npc_src)
         NPC_REDIRECT: target = redirect_target;
         NPC_HOLD:     target = pc_q;
         NPC_RAS:      target = ras_top;
         NPC_JUMP:     target = jump_target;
         default:      target = link;
      endcase
      // Loaded addresses never carry bit 0; misalign only flags bit 1.
      pc_d       = target & ~XLEN'(1);
      misalign_d = !C_EXT && target[1];
      if (npc_src == NPC_HOLD) begin
         pc_d       = pc_q;
         misalign_d = misalign_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   return_address_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .replace   (ras_replace),
      .push_data (link),
      .top       (ras_top),
      .count     (ras_count)
   );

   assign pc       = pc_q;
   assign misalign = misalign_q;

endmodule : pc_unit
